// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries; flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem reads, buffered output with redirect flush.
// Optional FETCH_ALIGN_CHECK_EN adds misalign_fault and a HALT state on misaligned redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic            misalign_fault,
`endif
  output fetch_state_t    dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // the producer holds valid and payload stable until that edge.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic            redir_go, acc, rsp_stale, rsp_live;
  logic [XLEN-1:0] target_pc;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*XLEN-1:0] head;

  assign redir_go  = redirect_valid && (state_q != HALT);
  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic redir_bad;
  assign redir_bad      = redir_go && (redirect_pc[1:0] != 2'b00);
  assign misalign_fault = fault_q;
`else
  logic unused_align_bits;
  assign unused_align_bits = ^redirect_pc[1:0];
`endif

  // out_cnt counts live reads only; reads orphaned by a redirect move into disc.
  assign imem_req_valid = !reset && (state_q == FETCH) && !redir_go &&
                          (({1'b0, fifo_count} + {1'b0, out_cnt_q}) < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign acc            = imem_req_valid && imem_req_ready;
  assign rsp_stale      = imem_rsp_valid && (disc_q != '0);
  assign rsp_live       = imem_rsp_valid && (disc_q == '0) && (out_cnt_q != '0) &&
                          (state_q != HALT);

  assign fifo_push   = rsp_live && !redir_go && !fifo_full;
  assign fifo_pop    = instr_valid && instr_ready && !redir_go;
  assign instr_valid = !fifo_empty && (state_q != HALT);
  assign instruction = instr_valid ? head[2*XLEN-1:XLEN] : NOP_INSTR;
  assign instr_pc    = instr_valid ? head[XLEN-1:0] : '0;
  assign dbg_state   = state_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redir_go),
    .push      (fifo_push),
    .push_data ({imem_rsp_data, rsp_pc_q}),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    out_cnt_d = out_cnt_q;
    disc_d    = disc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    if (redir_go) begin
      out_cnt_d = '0;
      disc_d    = disc_q + out_cnt_q + CW'(acc) - CW'(rsp_stale || rsp_live);
      pc_d      = target_pc;
      rsp_pc_d  = target_pc;
      state_d   = (disc_d != '0) ? DRAIN : FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redir_bad) begin
        fault_d = 1'b1;
        disc_d  = '0;
        state_d = HALT;
      end
`endif
    end else begin
      if (acc) begin
        pc_d = pc_q + PC_STEP;
      end
      if (rsp_live) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      out_cnt_d = out_cnt_q + CW'(acc) - CW'(rsp_live);
      disc_d    = disc_q - CW'(rsp_stale);
      if ((state_q == DRAIN) && (disc_d == '0)) begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      out_cnt_q <= '0;
      disc_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      out_cnt_q <= out_cnt_d;
      disc_q    <= disc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q   <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with an in-order memory model and expected-word queue.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the misalignment HALT path.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;
  fetch_state_t dbg_state;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_fault;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_fault (misalign_fault),
`endif
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit rand_ready = 0, rand_ir = 0, ir_val = 1, rst_val = 1;
  bit redir_req = 0, redir_arm = 0, redir_fired = 0;
  logic [31:0] redir_target = '0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] prev_addr = '0;
  bit stall_prev = 0;
  int first_acc = -1, first_vld = -1, pop_count = 0;
  logic [31:0] last_pop_pc = '0;

  logic [63:0] exp_q[$];
  logic [31:0] ma_q[$];
  int          md_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // one clock cycle: memory model, stimulus drive, scoreboard
  task automatic tick();
    logic [63:0] e;
    @(posedge clock);
    #1;
    cyc++;
    if (md_q.size() > 0 && md_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(ma_q.pop_front());
      void'(md_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    reset          = rst_val;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    instr_ready    = rand_ir ? 1'($urandom_range(0, 1)) : ir_val;
    redirect_valid = 1'b0;
    if (!rst_val && (redir_req || (redir_arm && imem_rsp_valid && instr_valid && instr_ready))) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_req      = 0;
      redir_arm      = 0;
      redir_fired    = 1;
    end
    #1;
    if (reset) begin
      exp_q.delete();
      exp_pc = RESET_PC;
    end else if (redirect_valid) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_during_redirect got %b want 0", imem_req_valid);
      end
      exp_q.delete();
      exp_pc = {redir_target[31:2], 2'b00};
    end else begin
      if (stall_prev && imem_req_valid) begin
        checks++;
        if (imem_req_addr !== prev_addr) begin
          errors++;
          $display("FAIL addr_stable got %h want %h", imem_req_addr, prev_addr);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin
          errors++;
          $display("FAIL req_addr got %h want %h", imem_req_addr, exp_pc);
        end
        exp_q.push_back({mem_word(exp_pc), exp_pc});
        exp_pc = exp_pc + 32'd4;
        if (first_acc < 0) first_acc = cyc;
      end
      if (instr_valid && first_vld < 0) first_vld = cyc;
      if (instr_valid && instr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got pc=%h want no word", instr_pc);
        end else begin
          e = exp_q.pop_front();
          if ({instruction, instr_pc} !== e) begin
            errors++;
            $display("FAIL pop_word got %h@%h want %h@%h", instruction, instr_pc, e[63:32], e[31:0]);
          end
        end
        pop_count++;
        last_pop_pc = instr_pc;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      ma_q.push_back(imem_req_addr);
      md_q.push_back(cyc + lat);
    end
    stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid && !reset;
    prev_addr  = imem_req_addr;
  endtask

  task automatic do_reset();
    rst_val = 1;
    repeat (6) tick();
    rst_val = 0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] want_pc);
    int start;
    int n;
    start = pop_count;
    n = 0;
    while (pop_count == start && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (pop_count == start) begin
      errors++;
      $display("FAIL %s_timeout got no word want pc %h", name, want_pc);
    end else if (last_pop_pc !== want_pc) begin
      errors++;
      $display("FAIL %s_pc got %h want %h", name, last_pop_pc, want_pc);
    end
  endtask

  task automatic test_reset();
    rst_val = 1;
    repeat (3) tick();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 32'h0 ||
        instruction !== NOP_INSTR || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_outputs got rv=%b iv=%b ins=%h ipc=%h addr=%h want 0 0 %h 0 %h",
               imem_req_valid, instr_valid, instruction, instr_pc, imem_req_addr, NOP_INSTR, RESET_PC);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (misalign_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault got %b want 0", misalign_fault);
    end
`endif
    rst_val = 0;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || dbg_state !== FETCH) begin
      errors++;
      $display("FAIL first_req got rv=%b st=%0d want 1 %0d", imem_req_valid, dbg_state, FETCH);
    end
  endtask

  task automatic test_stream();
    int start;
    lat = 1;
    do_reset();
    first_acc = -1;
    first_vld = -1;
    start = pop_count;
    repeat (30) tick();
    checks++;
    if (first_vld - first_acc !== 2) begin
      errors++;
      $display("FAIL first_latency got %0d want 2", first_vld - first_acc);
    end
    checks++;
    if (pop_count - start < 20) begin
      errors++;
      $display("FAIL stream_rate got %0d want >=20", pop_count - start);
    end
  endtask

  task automatic test_backpressure();
    int start;
    ir_val = 0;
    repeat (20) tick();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL full_buffer got rv=%b iv=%b held=%0d want 0 1 4",
               imem_req_valid, instr_valid, exp_q.size());
    end
    checks++;
    if (exp_q.size() > 0 && instr_pc !== exp_q[0][31:0]) begin
      errors++;
      $display("FAIL full_head got %h want %h", instr_pc, exp_q[0][31:0]);
    end
    ir_val = 1;
    start = pop_count;
    repeat (20) tick();
    checks++;
    if (pop_count - start < 10) begin
      errors++;
      $display("FAIL release_rate got %0d want >=10", pop_count - start);
    end
  endtask

  task automatic test_redirect_latency();
    lat = 3;
    do_reset();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL inflight got %0d want 2", exp_q.size());
    end
    redir_target = 32'h0000_0100;
    redir_req = 1;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || dbg_state !== DRAIN) begin
      errors++;
      $display("FAIL drain got rv=%b st=%0d want 0 %0d", imem_req_valid, dbg_state, DRAIN);
    end
    wait_pop("redir_lat", 32'h0000_0100);
  endtask

  task automatic test_redirect_collide();
    int n;
    lat = 1;
    ir_val = 1;
    repeat (10) tick();
    redir_target = 32'h0000_0200;
    redir_fired = 0;
    redir_arm = 1;
    n = 0;
    while (!redir_fired && n < 30) begin
      tick();
      n++;
    end
    redir_arm = 0;
    checks++;
    if (!redir_fired) begin
      errors++;
      $display("FAIL collide_timeout got no collision want one");
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_flush got iv=%b want 0", instr_valid);
    end
    wait_pop("collide", 32'h0000_0200);
  endtask

  task automatic test_random_ready();
    int start;
    lat = 2;
    rand_ready = 1;
    rand_ir = 1;
    start = pop_count;
    repeat (200) tick();
    rand_ready = 0;
    rand_ir = 0;
    repeat (20) tick();
    checks++;
    if (pop_count - start < 40) begin
      errors++;
      $display("FAIL random_rate got %0d want >=40", pop_count - start);
    end
  endtask

  task automatic test_align();
    lat = 2;
    redir_target = 32'h0000_0102;
    redir_req = 1;
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    tick();
    checks++;
    if (misalign_fault !== 1'b1 || dbg_state !== HALT) begin
      errors++;
      $display("FAIL fault_set got f=%b st=%0d want 1 %0d", misalign_fault, dbg_state, HALT);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misalign_fault !== 1'b1) begin
        errors++;
        $display("FAIL halt_quiet got rv=%b iv=%b f=%b want 0 0 1",
                 imem_req_valid, instr_valid, misalign_fault);
      end
    end
    do_reset();
    tick();
    checks++;
    if (misalign_fault !== 1'b0 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL fault_clear got f=%b rv=%b want 0 1", misalign_fault, imem_req_valid);
    end
`else
    wait_pop("align", 32'h0000_0100);
    repeat (10) tick();
`endif
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_collide();
    test_random_ready();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
